// File: rtl/eth_rx_filter_pkg.sv
// Shared types and constants for the Ethernet RX destination filter.
// Includes the destination-address match function.
package eth_rx_filter_pkg;

  localparam int ETH_HDR_ADDR_BYTES = 6;
  localparam int MAC_WIDTH = 48;
  localparam logic [MAC_WIDTH-1:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_REPLAY,
    ST_PASS,
    ST_DROP
  } state_e;

  typedef logic [2:0] idx_t;

  localparam idx_t HDR_LAST = idx_t'(ETH_HDR_ADDR_BYTES - 1);

  // Group bit is dst[40], the LSB of the first byte on the wire.
  function automatic logic mac_match(
    input logic [MAC_WIDTH-1:0] dst,
    input logic [MAC_WIDTH-1:0] own,
    input logic                 promisc,
    input logic                 bcast_en,
    input logic                 mcast_en
  );
    logic is_bcast;
    is_bcast = (dst == MAC_BCAST);
    return promisc
         | (dst == own)
         | (is_bcast & bcast_en)
         | (dst[40] & ~is_bcast & mcast_en);
  endfunction

endpackage

// File: rtl/eth_stat_counter.sv
// Saturating statistics counter.
// Clear has priority over a simultaneous increment.
module eth_stat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/eth_rx_dest_filter.sv
// Buffers the destination MAC, decides accept/drop, then replays
// the header and passes the rest of an accepted frame through.
module eth_rx_dest_filter
  import eth_rx_filter_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   logic_clk,
  input  logic                   logic_rst_n,
  input  logic [7:0]             s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tuser,
  output logic [7:0]             m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  input  logic [MAC_WIDTH-1:0]   cfg_station_mac,
  input  logic                   cfg_promisc,
  input  logic                   cfg_accept_bcast,
  input  logic                   cfg_accept_mcast,
  input  logic                   stat_clear,
  output logic [COUNT_WIDTH-1:0] stat_accept_count,
  output logic [COUNT_WIDTH-1:0] stat_drop_count,
  output logic [COUNT_WIDTH-1:0] stat_runt_count
);

  state_e state_q, state_d;
  idx_t   idx_q, idx_d;
  idx_t   ridx_q, ridx_d;
  logic   rdy_q;

  logic [7:0]           hdr_q [ETH_HDR_ADDR_BYTES];
  logic [MAC_WIDTH-1:0] mac_q;
  logic                 promisc_q;
  logic                 bcast_q;
  logic                 mcast_q;

  logic                 s_hs;
  logic                 hdr_we;
  logic                 cfg_we;
  logic                 acc_inc;
  logic                 drop_inc;
  logic                 runt_inc;
  logic [MAC_WIDTH-1:0] dst;

  assign s_hs = s_axis_tvalid & s_axis_tready;
  assign dst  = {hdr_q[0], hdr_q[1], hdr_q[2],
                 hdr_q[3], hdr_q[4], s_axis_tdata};

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    ridx_d        = ridx_q;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = hdr_q[ridx_q];
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    hdr_we        = 1'b0;
    cfg_we        = 1'b0;
    acc_inc       = 1'b0;
    drop_inc      = 1'b0;
    runt_inc      = 1'b0;
    unique case (state_q)
      ST_HDR: begin
        s_axis_tready = rdy_q;
        if (s_hs) begin
          hdr_we = 1'b1;
          cfg_we = (idx_q == '0);
          if (s_axis_tlast) begin
            runt_inc = 1'b1;
            idx_d    = '0;
          end else if (idx_q == HDR_LAST) begin
            idx_d  = '0;
            ridx_d = '0;
            // Config may change mid-header; use the copy taken at byte 0.
            if (mac_match(dst, mac_q, promisc_q, bcast_q, mcast_q)) begin
              acc_inc = 1'b1;
              state_d = ST_REPLAY;
            end else begin
              drop_inc = 1'b1;
              state_d  = ST_DROP;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_REPLAY: begin
        m_axis_tvalid = 1'b1;
        if (m_axis_tready) begin
          if (ridx_q == HDR_LAST) begin
            ridx_d  = '0;
            state_d = ST_PASS;
          end else begin
            ridx_d = ridx_q + 3'd1;
          end
        end
      end
      ST_PASS: begin
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = s_axis_tlast;
        m_axis_tuser  = s_axis_tuser;
        s_axis_tready = m_axis_tready;
        if (s_hs && s_axis_tlast) state_d = ST_HDR;
      end
      ST_DROP: begin
        s_axis_tready = 1'b1;
        if (s_hs && s_axis_tlast) state_d = ST_HDR;
      end
      default: state_d = ST_HDR;
    endcase
  end

  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      state_q <= ST_HDR;
      idx_q   <= '0;
      ridx_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ridx_q  <= ridx_d;
      rdy_q   <= 1'b1;
    end
  end

  always_ff @(posedge logic_clk) begin
    if (hdr_we) hdr_q[idx_q] <= s_axis_tdata;
    if (cfg_we) begin
      mac_q     <= cfg_station_mac;
      promisc_q <= cfg_promisc;
      bcast_q   <= cfg_accept_bcast;
      mcast_q   <= cfg_accept_mcast;
    end
  end

  eth_stat_counter #(.W(COUNT_WIDTH)) u_acc_cnt (
    .clk_i  (logic_clk),
    .rst_ni (logic_rst_n),
    .clr_i  (stat_clear),
    .inc_i  (acc_inc),
    .cnt_o  (stat_accept_count)
  );

  eth_stat_counter #(.W(COUNT_WIDTH)) u_drop_cnt (
    .clk_i  (logic_clk),
    .rst_ni (logic_rst_n),
    .clr_i  (stat_clear),
    .inc_i  (drop_inc),
    .cnt_o  (stat_drop_count)
  );

  eth_stat_counter #(.W(COUNT_WIDTH)) u_runt_cnt (
    .clk_i  (logic_clk),
    .rst_ni (logic_rst_n),
    .clr_i  (stat_clear),
    .inc_i  (runt_inc),
    .cnt_o  (stat_runt_count)
  );

endmodule

// File: tb/tb_eth_rx_dest_filter.sv
// Directed bench for eth_rx_dest_filter: filtering, replay,
// runts, backpressure, counter saturation and mid-frame reset.
module tb_eth_rx_dest_filter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic        s_tuser;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        m_tuser;
  logic [47:0] mac;
  logic        promisc;
  logic        bcast;
  logic        mcast;
  logic        sclr;
  logic [15:0] acc_cnt;
  logic [15:0] drop_cnt;
  logic [15:0] runt_cnt;

  int checks = 0;
  int errors = 0;
  int exp_acc = 0;
  int exp_drop = 0;
  int exp_runt = 0;

  logic [9:0] rx_q[$];
  logic [9:0] exp_q[$];
  logic [7:0] cur_f[$];
  bit         mv_seen;
  bit         sr_low;
  bit         stab_err;
  bit         hold_pend;
  logic [9:0] hold_v;
  bit         bp_en = 1'b0;

  localparam logic [47:0] STN = 48'h02_00_00_00_00_01;

  always #5 clk = ~clk;

  eth_rx_dest_filter #(.COUNT_WIDTH(16)) dut (
    .logic_clk         (clk),
    .logic_rst_n       (rst_n),
    .s_axis_tdata      (s_tdata),
    .s_axis_tvalid     (s_tvalid),
    .s_axis_tready     (s_tready),
    .s_axis_tlast      (s_tlast),
    .s_axis_tuser      (s_tuser),
    .m_axis_tdata      (m_tdata),
    .m_axis_tvalid     (m_tvalid),
    .m_axis_tready     (m_tready),
    .m_axis_tlast      (m_tlast),
    .m_axis_tuser      (m_tuser),
    .cfg_station_mac   (mac),
    .cfg_promisc       (promisc),
    .cfg_accept_bcast  (bcast),
    .cfg_accept_mcast  (mcast),
    .stat_clear        (sclr),
    .stat_accept_count (acc_cnt),
    .stat_drop_count   (drop_cnt),
    .stat_runt_count   (runt_cnt)
  );

  // Inputs change 1ns after posedge; observe on the negedge.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_tvalid) mv_seen = 1'b1;
      if (s_tvalid && !s_tready && rst_n) sr_low = 1'b1;
      if (hold_pend && (!m_tvalid ||
          {m_tuser, m_tlast, m_tdata} != hold_v))
        stab_err = 1'b1;
      hold_pend = m_tvalid && !m_tready;
      hold_v    = {m_tuser, m_tlast, m_tdata};
      if (m_tvalid && m_tready)
        rx_q.push_back({m_tuser, m_tlast, m_tdata});
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_byte(input logic [7:0] d,
                            input logic l, input logic u);
    bit ok;
    int n;
    s_tdata  = d;
    s_tlast  = l;
    s_tuser  = u;
    s_tvalid = 1'b1;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = s_tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drive_timeout: s_tready=0 required 1");
    end
  endtask

  // Builds cur_f; when fwd is set also appends it to exp_q.
  task automatic build(input logic [47:0] da, input int len,
                       input int seed, input logic u, input bit fwd);
    cur_f.delete();
    for (int i = 0; i < len; i++) begin
      if (i < 6) cur_f.push_back(da[47-8*i -: 8]);
      else cur_f.push_back(8'(seed * 13 + i * 7));
    end
    if (fwd) begin
      for (int i = 0; i < len; i++)
        exp_q.push_back({(i == len - 1) ? u : 1'b0,
                         (i == len - 1), cur_f[i]});
    end
  endtask

  task automatic send_cur(input logic u, input bit drop_valid);
    for (int i = 0; i < cur_f.size(); i++)
      drive_byte(cur_f[i], i == cur_f.size() - 1,
                 (i == cur_f.size() - 1) ? u : 1'b0);
    if (drop_valid) s_tvalid = 1'b0;
  endtask

  function automatic bit rx_ok();
    if (rx_q.size() != exp_q.size()) return 1'b0;
    for (int i = 0; i < rx_q.size(); i++)
      if (rx_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic start_frame();
    rx_q.delete();
    exp_q.delete();
    mv_seen = 1'b0;
    sr_low  = 1'b0;
  endtask

  task automatic check_counts(input string nm);
    checks++;
    if (acc_cnt !== 16'(exp_acc) || drop_cnt !== 16'(exp_drop) ||
        runt_cnt !== 16'(exp_runt)) begin
      errors++;
      $display("FAIL %s counts: acc/drop/runt=%0d/%0d/%0d required %0d/%0d/%0d",
               nm, acc_cnt, drop_cnt, runt_cnt, exp_acc, exp_drop, exp_runt);
    end
  endtask

  task automatic test_reset();
    idle(3);
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b0 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: s_tready=%b m_tvalid=%b required 0 0",
               s_tready, m_tvalid);
    end
    check_counts("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_clock: s_tready=%b required 0", s_tready);
    end
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_clock: s_tready=%b required 1", s_tready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_station();
    start_frame();
    build(STN, 64, 1, 1'b0, 1'b1);
    send_cur(1'b0, 1'b1);
    idle(3);
    exp_acc++;
    checks++;
    if (rx_ok() !== 1'b1) begin
      errors++;
      $display("FAIL station_fwd: got %0d bytes required %0d",
               rx_q.size(), exp_q.size());
    end
    check_counts("station");
  endtask

  task automatic test_unicast_other();
    start_frame();
    build(48'h02_00_00_00_00_02, 30, 2, 1'b0, 1'b0);
    send_cur(1'b0, 1'b1);
    idle(3);
    exp_drop++;
    checks++;
    if (mv_seen || sr_low || rx_q.size() != 0) begin
      errors++;
      $display("FAIL other_drop: m_tvalid_seen=%b s_tready_low=%b bytes=%0d required 0 0 0",
               mv_seen, sr_low, rx_q.size());
    end
    check_counts("other_drop");
    promisc = 1'b1;
    start_frame();
    build(48'h02_00_00_00_00_02, 30, 3, 1'b0, 1'b1);
    send_cur(1'b0, 1'b1);
    idle(3);
    exp_acc++;
    promisc = 1'b0;
    checks++;
    if (rx_ok() !== 1'b1) begin
      errors++;
      $display("FAIL promisc_fwd: got %0d bytes required %0d",
               rx_q.size(), exp_q.size());
    end
    check_counts("promisc");
  endtask

  task automatic test_group();
    start_frame();
    build(48'hFF_FF_FF_FF_FF_FF, 20, 4, 1'b0, 1'b0);
    send_cur(1'b0, 1'b1);
    idle(3);
    exp_drop++;
    checks++;
    if (mv_seen || rx_q.size() != 0) begin
      errors++;
      $display("FAIL bcast_drop: bytes=%0d required 0", rx_q.size());
    end
    bcast = 1'b1;
    start_frame();
    build(48'hFF_FF_FF_FF_FF_FF, 20, 5, 1'b0, 1'b1);
    send_cur(1'b0, 1'b1);
    idle(3);
    exp_acc++;
    checks++;
    if (rx_ok() !== 1'b1) begin
      errors++;
      $display("FAIL bcast_fwd: got %0d bytes required %0d",
               rx_q.size(), exp_q.size());
    end
    bcast = 1'b0;
    start_frame();
    build(48'h01_00_5E_00_00_01, 20, 6, 1'b0, 1'b0);
    send_cur(1'b0, 1'b1);
    idle(3);
    exp_drop++;
    checks++;
    if (mv_seen || rx_q.size() != 0) begin
      errors++;
      $display("FAIL mcast_drop: bytes=%0d required 0", rx_q.size());
    end
    mcast = 1'b1;
    start_frame();
    build(48'h01_00_5E_00_00_01, 20, 7, 1'b0, 1'b1);
    send_cur(1'b0, 1'b1);
    idle(3);
    exp_acc++;
    checks++;
    if (rx_ok() !== 1'b1) begin
      errors++;
      $display("FAIL mcast_fwd: got %0d bytes required %0d",
               rx_q.size(), exp_q.size());
    end
    // Broadcast is not multicast when only mcast is enabled.
    start_frame();
    build(48'hFF_FF_FF_FF_FF_FF, 20, 8, 1'b0, 1'b0);
    send_cur(1'b0, 1'b1);
    idle(3);
    exp_drop++;
    mcast = 1'b0;
    checks++;
    if (mv_seen || rx_q.size() != 0) begin
      errors++;
      $display("FAIL bcast_not_mcast: bytes=%0d required 0", rx_q.size());
    end
    check_counts("group");
  endtask

  task automatic test_runt();
    start_frame();
    build(STN, 4, 9, 1'b0, 1'b0);
    send_cur(1'b0, 1'b1);
    idle(3);
    exp_runt++;
    checks++;
    if (mv_seen || rx_q.size() != 0) begin
      errors++;
      $display("FAIL runt_discard: bytes=%0d required 0", rx_q.size());
    end
    check_counts("runt");
    start_frame();
    build(STN, 25, 10, 1'b0, 1'b1);
    send_cur(1'b0, 1'b1);
    idle(3);
    exp_acc++;
    checks++;
    if (rx_ok() !== 1'b1) begin
      errors++;
      $display("FAIL after_runt_fwd: got %0d bytes required %0d",
               rx_q.size(), exp_q.size());
    end
    start_frame();
    build(STN, 7, 11, 1'b1, 1'b1);
    send_cur(1'b1, 1'b1);
    idle(3);
    exp_acc++;
    checks++;
    if (rx_ok() !== 1'b1) begin
      errors++;
      $display("FAIL seven_byte_fwd: got %0d bytes required %0d",
               rx_q.size(), exp_q.size());
    end
    check_counts("seven_byte");
  endtask

  task automatic test_back_to_back();
    start_frame();
    stab_err = 1'b0;
    bp_en = 1'b1;
    for (int f = 0; f < 100; f++) begin
      build(STN, 7 + (f % 24), 20 + f, 1'(f % 3 == 0), 1'b1);
      send_cur(1'(f % 3 == 0), 1'b0);
    end
    s_tvalid = 1'b0;
    bp_en = 1'b0;
    idle(5);
    exp_acc += 100;
    checks++;
    if (rx_ok() !== 1'b1) begin
      errors++;
      $display("FAIL b2b_stream: got %0d bytes required %0d",
               rx_q.size(), exp_q.size());
    end
    checks++;
    if (stab_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hold: unstable=%b required 0", stab_err);
    end
    check_counts("b2b");
  endtask

  task automatic test_saturate_clear();
    sclr = 1'b1;
    idle(1);
    sclr = 1'b0;
    exp_acc = 0;
    exp_drop = 0;
    exp_runt = 0;
    check_counts("clear");
    for (int i = 0; i < 65536; i++) drive_byte(8'h00, 1'b1, 1'b0);
    s_tvalid = 1'b0;
    idle(1);
    exp_runt = 65535;
    check_counts("saturate");
    sclr = 1'b1;
    drive_byte(8'h00, 1'b1, 1'b0);
    sclr = 1'b0;
    s_tvalid = 1'b0;
    idle(1);
    exp_runt = 0;
    check_counts("clear_wins");
  endtask

  task automatic test_reset_mid();
    start_frame();
    build(STN, 40, 50, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive_byte(cur_f[i], 1'b0, 1'b0);
    exp_acc = 1;
    check_counts("pre_reset");
    rst_n = 1'b0;
    s_tvalid = 1'b0;
    #2;
    exp_acc = 0;
    checks++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: m_tvalid=%b s_tready=%b required 0 0",
               m_tvalid, s_tready);
    end
    check_counts("mid_reset");
    idle(2);
    rst_n = 1'b1;
    idle(1);
    start_frame();
    build(STN, 30, 51, 1'b0, 1'b1);
    send_cur(1'b0, 1'b1);
    idle(3);
    exp_acc = 1;
    checks++;
    if (rx_ok() !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_fwd: got %0d bytes required %0d",
               rx_q.size(), exp_q.size());
    end
    check_counts("post_reset");
  endtask

  initial begin
    rst_n    = 1'b1;
    s_tdata  = 8'h00;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    mac      = STN;
    promisc  = 1'b0;
    bcast    = 1'b0;
    mcast    = 1'b0;
    sclr     = 1'b0;
    #2;
    rst_n = 1'b0;
    test_reset();
    test_station();
    test_unicast_other();
    test_group();
    test_runt();
    test_back_to_back();
    test_saturate_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
